// File: rtl/p4_router_pkt_checker.sv
// p4_router_pkt_checker
// Checks one 64-bit AXIS egress stream from the P4 router against the format
// produced by the matching packet generator. It also keeps loopback statistics.
//   word0 = {magic[63:48], port[47:32], seq[31:16], len_bytes[15:0]}
//   payload byte k (packet byte 8+k) = seq[7:0] + k, byte 0 in tdata[7:0]
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   tdata/tkeep/tlast/tvalid/tready   AXIS slave, 8 data bytes
//   clear                 zero counters/sticky flags, re-arm sequence tracking
//   pkt_done, pkt_ok      1-cycle completion pulse and its clean/errored flag
//   pkt_count, byte_count, err_count, err_sticky   statistics
//   err_sticky = {tkeep, payload, len, seq, hdr}
module p4_router_pkt_checker #(
   parameter int unsigned PORT_ID         = 0,
   parameter int unsigned MTU_BYTES       = 2000,
   parameter bit          BACKPRESSURE_EN = 1'b0,
   parameter logic [15:0] MAGIC           = 16'h4B50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] tdata,
   input  logic [7:0]  tkeep,
   input  logic        tlast,
   input  logic        tvalid,
   output logic        tready,
   input  logic        clear,
   output logic        pkt_done,
   output logic        pkt_ok,
   output logic [31:0] pkt_count,
   output logic [47:0] byte_count,
   output logic [15:0] err_count,
   output logic [4:0]  err_sticky
);

   localparam int unsigned DATA_BYTES = 8;
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;   // x^16 + x^14 + x^13 + x^11 + 1

   typedef enum logic {S_HDR, S_PAY} state_t;

   state_t      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        seq_armed_q;
   logic [15:0] exp_seq_q;
   logic [15:0] len_field_q;
   logic [15:0] run_len_q;
   logic [7:0]  base_q;
   logic        skip_q;        // payload compare disabled for the rest of the packet
   logic [4:0]  err_q;         // errors so far in the packet in flight

   logic        accept_c, is_hdr_c, keep_ok_c;
   logic        hdr_bad_c, seq_bad_c, lenf_bad_c, mtu_over_c, pay_bad_c, skip_c;
   logic [3:0]  pcnt_c;
   logic [16:0] len_sum_c;
   logic [15:0] run_len_c, len_field_c;
   logic [7:0]  exp_byte_c;
   logic [4:0]  err_c;         // packet errors including the current beat

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_HDR;
      else       state_q <= state_d;
   end

   // Next state and per-beat checks
   always_comb begin
      state_d     = state_q;
      accept_c    = tvalid & tready;
      is_hdr_c    = (state_q == S_HDR);
      pcnt_c      = 4'($countones(tkeep));
      // contiguous-from-LSB means tkeep+1 is a power of two (or wraps to 0)
      keep_ok_c   = tlast ? ((tkeep & (tkeep + 8'd1)) == 8'd0) : (tkeep == 8'hFF);
      hdr_bad_c   = (tdata[63:48] != MAGIC) || (tdata[47:32] != 16'(PORT_ID));
      seq_bad_c   = seq_armed_q && (tdata[31:16] != exp_seq_q);
      lenf_bad_c  = (tdata[15:0] < 16'd8) || (17'(tdata[15:0]) > 17'(MTU_BYTES));
      len_sum_c   = 17'(is_hdr_c ? 16'd0 : run_len_q) + 17'(pcnt_c);
      run_len_c   = len_sum_c[16] ? 16'hFFFF : len_sum_c[15:0];
      mtu_over_c  = len_sum_c > 17'(MTU_BYTES);
      len_field_c = is_hdr_c ? tdata[15:0] : len_field_q;

      // run_len_q is the packet offset of lane 0; payload starts at offset 8
      pay_bad_c  = 1'b0;
      exp_byte_c = 8'd0;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         exp_byte_c = base_q + run_len_q[7:0] - 8'd8 + 8'(i);
         if (tkeep[i] && (tdata[8*i +: 8] != exp_byte_c)) pay_bad_c = 1'b1;
      end
      if (is_hdr_c || skip_q) pay_bad_c = 1'b0;

      skip_c   = (is_hdr_c ? hdr_bad_c : skip_q) | mtu_over_c;
      err_c[0] = is_hdr_c ? hdr_bad_c : err_q[0];
      err_c[1] = is_hdr_c ? seq_bad_c : err_q[1];
      err_c[2] = (is_hdr_c ? lenf_bad_c : err_q[2]) | mtu_over_c
               | (tlast && (run_len_c != len_field_c));
      err_c[3] = (!is_hdr_c && err_q[3]) | pay_bad_c;
      err_c[4] = (!is_hdr_c && err_q[4]) | !keep_ok_c;

      if (accept_c) state_d = tlast ? S_HDR : S_PAY;

      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   // Packet tracking, statistics and tready
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q      <= LFSR_SEED;
         tready      <= 1'b0;
         pkt_done    <= 1'b0;
         pkt_ok      <= 1'b0;
         pkt_count   <= 32'd0;
         byte_count  <= 48'd0;
         err_count   <= 16'd0;
         err_sticky  <= 5'd0;
         seq_armed_q <= 1'b0;
         exp_seq_q   <= 16'd0;
         len_field_q <= 16'd0;
         run_len_q   <= 16'd0;
         base_q      <= 8'd0;
         skip_q      <= 1'b0;
         err_q       <= 5'd0;
      end else begin
         lfsr_q   <= lfsr_d;
         tready   <= BACKPRESSURE_EN ? (lfsr_d[0] | lfsr_d[1]) : 1'b1;
         pkt_done <= accept_c & tlast;
         pkt_ok   <= accept_c & tlast & ~|err_c;

         if (accept_c) begin
            run_len_q   <= run_len_c;
            len_field_q <= len_field_c;
            skip_q      <= skip_c;
            err_q       <= err_c;
            if (is_hdr_c) begin
               // resync on the received seq even when it was wrong
               base_q      <= tdata[23:16];
               exp_seq_q   <= tdata[31:16] + 16'd1;
               seq_armed_q <= 1'b1;
            end
         end

         if (accept_c && tlast) begin
            pkt_count  <= pkt_count + 32'd1;
            byte_count <= byte_count + 48'(run_len_c);
            err_sticky <= err_sticky | err_c;
            if (|err_c && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
         end

         // clear overrides a same-cycle completion update; FSM keeps running
         if (clear) begin
            pkt_count   <= 32'd0;
            byte_count  <= 48'd0;
            err_count   <= 16'd0;
            err_sticky  <= 5'd0;
            seq_armed_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_p4_router_pkt_checker.sv
// Testbench for p4_router_pkt_checker: directed packets, scoreboard of expected
// completions popped by a monitor on pkt_done, plus a backpressure instance.
module tb_p4_router_pkt_checker;

   localparam logic [15:0] MAGIC        = 16'h4B50;
   localparam int          BEAT_BUDGET  = 200;

   typedef struct {
      logic        ok;
      logic [31:0] pc;
      logic [47:0] bc;
      logic [15:0] ec;
      logic [4:0]  st;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clear, b_clear;
   logic [63:0] tdata, b_tdata;
   logic [7:0]  tkeep, b_tkeep;
   logic        tlast, tvalid, tready, b_tlast, b_tvalid, b_tready;
   logic        pkt_done, pkt_ok, b_done, b_ok;
   logic [31:0] pkt_count, b_pkt_count;
   logic [47:0] byte_count, b_byte_count;
   logic [15:0] err_count, b_err_count;
   logic [4:0]  err_sticky, b_err_sticky;

   p4_router_pkt_checker #(.PORT_ID(0), .MTU_BYTES(2000), .BACKPRESSURE_EN(1'b0), .MAGIC(MAGIC)) dut (
      .clk(clk), .reset(reset), .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tvalid(tvalid),
      .tready(tready), .clear(clear), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
      .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count), .err_sticky(err_sticky));

   p4_router_pkt_checker #(.PORT_ID(0), .MTU_BYTES(2000), .BACKPRESSURE_EN(1'b1), .MAGIC(MAGIC)) dut_bp (
      .clk(clk), .reset(reset), .tdata(b_tdata), .tkeep(b_tkeep), .tlast(b_tlast), .tvalid(b_tvalid),
      .tready(b_tready), .clear(b_clear), .pkt_done(b_done), .pkt_ok(b_ok),
      .pkt_count(b_pkt_count), .byte_count(b_byte_count), .err_count(b_err_count),
      .err_sticky(b_err_sticky));

   int n_checks = 0;
   int n_errors = 0;
   exp_t sbq[$];

   // bench model of the statistics
   logic [31:0] m_pc = '0;
   logic [47:0] m_bc = '0;
   logic [15:0] m_ec = '0;
   logic [4:0]  m_st = '0;

   int bp_run = 0, bp_cyc = 0, bp_rdy = 0, bp_done_n = 0, bp_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic model_clear();
      m_pc = '0; m_bc = '0; m_ec = '0; m_st = '0;
   endtask

   function automatic logic [63:0] pay_word(input logic [15:0] seq, input int b);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = seq[7:0] + 8'(8*b + i - 8);
      return w;
   endfunction

   // Send one packet on the main DUT; push its expected completion
   task automatic send(input logic [15:0] magic, input logic [15:0] seq, input logic [15:0] len,
                       input int nbytes, input logic [7:0] last_keep, input int flip,
                       input logic [4:0] exp_err, input bit clr_last);
      int nbeats, rem, rx, n;
      logic [63:0] w;
      logic [7:0]  k;
      exp_t e;
      nbeats = (nbytes + 7) / 8;
      rem    = nbytes - 8*(nbeats - 1);
      rx     = 0;
      for (int b = 0; b < nbeats; b++) begin
         w = (b == 0) ? {magic, 16'h0000, seq, len} : pay_word(seq, b);
         if (flip >= 0 && flip / 8 == b) w[8*(flip % 8) +: 8] = ~w[8*(flip % 8) +: 8];
         if (b < nbeats - 1)     k = 8'hFF;
         else if (last_keep != 0) k = last_keep;
         else                     k = 8'((1 << rem) - 1);
         rx += $countones(k);
         tdata = w; tkeep = k; tlast = (b == nbeats - 1); tvalid = 1'b1;
         n = 0;
         while (!tready && n < BEAT_BUDGET) begin @(negedge clk); n++; end
         if (!tready) begin
            n_checks++; n_errors++;
            $display("FAIL beat_timeout: tready got 0 expected 1 (seq %0h beat %0d)", seq, b);
         end
         if (b == nbeats - 1) begin
            if (clr_last) begin
               clear = 1'b1;
               model_clear();
            end else begin
               m_pc += 32'd1;
               m_bc += 48'(rx);
               if (|exp_err) m_ec += 16'd1;
               m_st |= exp_err;
            end
            e.ok = ~|exp_err; e.pc = m_pc; e.bc = m_bc; e.ec = m_ec; e.st = m_st;
            sbq.push_back(e);
         end
         @(negedge clk);
      end
      tvalid = 1'b0; tlast = 1'b0; clear = 1'b0;
   endtask

   // Good 3-beat packet on the backpressure instance
   task automatic send_bp(input logic [15:0] seq);
      int n;
      for (int b = 0; b < 3; b++) begin
         b_tdata  = (b == 0) ? {MAGIC, 16'h0000, seq, 16'd24} : pay_word(seq, b);
         b_tkeep  = 8'hFF;
         b_tlast  = (b == 2);
         b_tvalid = 1'b1;
         n = 0;
         while (!b_tready && n < BEAT_BUDGET) begin @(negedge clk); n++; end
         if (!b_tready) begin
            n_checks++; n_errors++;
            $display("FAIL bp_beat_timeout: tready got 0 expected 1 (seq %0h)", seq);
         end
         @(negedge clk);
      end
      b_tvalid = 1'b0; b_tlast = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   // Scoreboard monitor for the main instance
   always @(negedge clk) begin
      if (pkt_done) begin
         if (sbq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_done: pkt_done got 1 expected 0");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pkt_ok",     64'(pkt_ok),     64'(e.ok));
            chk("pkt_count",  64'(pkt_count),  64'(e.pc));
            chk("byte_count", 64'(byte_count), 64'(e.bc));
            chk("err_count",  64'(err_count),  64'(e.ec));
            chk("err_sticky", 64'(err_sticky), 64'(e.st));
         end
      end
   end

   // Backpressure instance statistics
   always @(negedge clk) begin
      if (bp_run != 0) begin
         bp_cyc++;
         if (b_tready) bp_rdy++;
      end
      if (b_done) begin
         bp_done_n++;
         if (!b_ok) bp_bad++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; b_clear = 1'b0;
      tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
      b_tdata = '0; b_tkeep = '0; b_tlast = 1'b0; b_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tready",     64'(tready),     64'd0);
      chk("rst_pkt_done",   64'(pkt_done),   64'd0);
      chk("rst_pkt_count",  64'(pkt_count),  64'd0);
      chk("rst_byte_count", 64'(byte_count), 64'd0);
      chk("rst_err_count",  64'(err_count),  64'd0);
      chk("rst_err_sticky", 64'(err_sticky), 64'd0);
      chk("rst_bp_tready",  64'(b_tready),   64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("tready_high", 64'(tready), 64'd1);

      // good packets
      for (int s = 5; s <= 7; s++) send(MAGIC, 16'(s), 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      settle();
      chk("t1_pkt_count",  64'(pkt_count),  64'd3);
      chk("t1_byte_count", 64'(byte_count), 64'd192);
      chk("t1_err_count",  64'(err_count),  64'd0);

      // sequence gap and wrap
      do_clear();
      send(MAGIC, 16'hFFFF, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      send(MAGIC, 16'h0000, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      send(MAGIC, 16'h0002, 16'd64, 64, 8'h00, -1, 5'b00010, 1'b0);
      send(MAGIC, 16'h0003, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      settle();
      chk("t2_err_count",  64'(err_count),  64'd1);
      chk("t2_err_sticky", 64'(err_sticky), 64'h02);
      chk("t2_pkt_count",  64'(pkt_count),  64'd4);

      // length and tkeep
      do_clear();
      send(MAGIC, 16'd30, 16'd20, 20, 8'h0F, -1, 5'b00000, 1'b0);
      send(MAGIC, 16'd31, 16'd20, 20, 8'h05, -1, 5'b10100, 1'b0);
      send(MAGIC, 16'd32, 16'd24, 20, 8'h0F, -1, 5'b00100, 1'b0);
      settle();
      chk("t3_err_sticky", 64'(err_sticky), 64'h14);
      chk("t3_err_count",  64'(err_count),  64'd2);

      // payload corruption at packet byte 13
      do_clear();
      send(MAGIC, 16'd10, 16'd64, 64, 8'h00, 13, 5'b01000, 1'b0);
      settle();
      chk("t4_err_sticky", 64'(err_sticky), 64'h08);
      chk("t4_pkt_count",  64'(pkt_count),  64'd1);

      // header error, then a good packet
      do_clear();
      send(16'h0000, 16'd40, 16'd64, 64, 8'h00, -1, 5'b00001, 1'b0);
      send(MAGIC,    16'd41, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      settle();
      chk("t5_err_sticky", 64'(err_sticky), 64'h01);
      chk("t5_pkt_count",  64'(pkt_count),  64'd2);

      // reset in the middle of a packet
      tdata = {MAGIC, 16'h0000, 16'd99, 16'd64}; tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b1;
      repeat (3) @(negedge clk);
      tvalid = 1'b0; reset = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      chk("t6_rst_tready",    64'(tready),    64'd0);
      chk("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      send(MAGIC, 16'd100, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b0);
      // clear on the tlast beat: counters read 0 at pkt_done
      send(MAGIC, 16'd101, 16'd64, 64, 8'h00, -1, 5'b00000, 1'b1);
      settle();
      chk("t6_clr_pkt_count",  64'(pkt_count),  64'd0);
      chk("t6_clr_byte_count", 64'(byte_count), 64'd0);
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      // backpressure instance: 1000 good packets
      bp_run = 1;
      for (int s = 0; s < 1000; s++) send_bp(16'(s));
      bp_run = 0;
      settle();
      chk("bp_done_pulses", 64'(bp_done_n),   64'd1000);
      chk("bp_not_ok",      64'(bp_bad),      64'd0);
      chk("bp_pkt_count",   64'(b_pkt_count), 64'd1000);
      chk("bp_err_count",   64'(b_err_count), 64'd0);
      chk("bp_duty_in_65_85", 64'((bp_rdy * 100 >= bp_cyc * 65) && (bp_rdy * 100 <= bp_cyc * 85)), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
